// File: rtl/synth_pkg.sv
// Shared constants and state encoding for the voice mix / normalise / PWM path.
package synth_pkg;

    localparam int NUM_VOICES = 12;
    localparam int SAMPLE_W   = 8;
    localparam int ACC_W      = 12;
    localparam int CNT_W      = 4;
    localparam int IDX_W      = $clog2(NUM_VOICES);

    // Largest possible sum of all voices at full scale; must fit in ACC_W bits.
    localparam int MAX_SUM    = NUM_VOICES * ((1 << SAMPLE_W) - 1);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DIV_REQ,
        DIV_WAIT,
        OUTPUT
    } seq_state_t;

endpackage

// File: rtl/mix_sequencer.sv
// Per-sample mix controller: snapshots the voices on each sample tick, serially
// sums the enabled ones, normalises through the shared divider and hands the
// 8-bit result to the PWM stage with a one-cycle valid strobe.
module mix_sequencer
    import synth_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           sample_now,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] samples,
    input  logic [NUM_VOICES-1:0]          sample_enable,
    output logic                           div_start,
    output logic [ACC_W-1:0]               div_dividend,
    output logic [ACC_W-1:0]               div_divisor,
    input  logic                           div_done,
    input  logic [SAMPLE_W-1:0]            div_quotient,
    output logic [SAMPLE_W-1:0]            final_sample,
    output logic                           final_valid,
    output logic                           busy,
    output logic                           overrun,
    output logic [CNT_W-1:0]               voice_count
);

    // A full-scale sum of every voice must never wrap the accumulator.
    if (MAX_SUM >= (1 << ACC_W)) begin : g_acc_width_check
        $error("mix_sequencer: ACC_W too narrow for NUM_VOICES full-scale samples");
    end

    seq_state_t state, state_next;

    logic [SAMPLE_W-1:0]   snap_sample [NUM_VOICES];
    logic [NUM_VOICES-1:0] snap_en;
    logic [ACC_W-1:0]      acc;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;

    logic [ACC_W-1:0]      acc_next;
    logic [CNT_W-1:0]      cnt_next;
    logic                  last_voice;

    // Running sum and count including the voice currently addressed by idx.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        acc_next = acc;
        cnt_next = cnt;
        if (snap_en[idx]) begin
            acc_next = acc + ACC_W'(snap_sample[idx]);
            cnt_next = cnt + CNT_W'(1);
        end
    end

    assign last_voice = (idx == IDX_W'(NUM_VOICES - 1));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode and the one-cycle strobes, which are pure state decodes.
    always_comb begin
        state_next  = state;
        div_start   = 1'b0;
        final_valid = 1'b0;
        busy        = (state != IDLE);
        case (state)
            IDLE:     if (sample_now) state_next = SCAN;
            SCAN:     if (last_voice) state_next = (cnt_next != '0) ? DIV_REQ : OUTPUT;
            DIV_REQ: begin
                div_start  = 1'b1;
                state_next = DIV_WAIT;
            end
            DIV_WAIT: if (div_done) state_next = OUTPUT;
            OUTPUT: begin
                final_valid = 1'b1;
                state_next  = IDLE;
            end
            default:  state_next = IDLE;
        endcase
    end

    // Snapshot, serial accumulate, divider operands and the held output sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the snapshot array is a handful of flops, cleared with everything else so a reset leaves no stale voice data.
            for (int i = 0; i < NUM_VOICES; i++) snap_sample[i] <= '0;
            snap_en      <= '0;
            acc          <= '0;
            cnt          <= '0;
            idx          <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
            final_sample <= '0;
            voice_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sample_now) begin
                        for (int i = 0; i < NUM_VOICES; i++)
                            snap_sample[i] <= samples[i*SAMPLE_W +: SAMPLE_W];
                        snap_en <= sample_enable;
                        acc     <= '0;
                        cnt     <= '0;
                        idx     <= '0;
                    end
                end
                SCAN: begin
                    acc <= acc_next;
                    cnt <= cnt_next;
                    idx <= idx + IDX_W'(1);
                    if (last_voice) begin
                        div_dividend <= acc_next;
                        div_divisor  <= ACC_W'(cnt_next);
                        voice_count  <= cnt_next;
                        // With no voices keyed the divider is skipped and silence is output.
                        if (cnt_next == '0) final_sample <= '0;
                    end
                end
                DIV_WAIT: if (div_done) final_sample <= div_quotient;
                default: ;
            endcase
        end
    end

    // A tick that lands while a transaction is in flight is dropped and flagged until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          overrun <= 1'b0;
        else if (state != IDLE && sample_now) overrun <= 1'b1;
    end

endmodule

// File: tb/tb_mix_sequencer.sv
// Directed bench for mix_sequencer with a simple fixed-latency divider model.
module tb_mix_sequencer;
    import synth_pkg::*;

    logic                           clk = 1'b0;
    logic                           reset;
    logic                           sample_now;
    logic [NUM_VOICES*SAMPLE_W-1:0] samples;
    logic [NUM_VOICES-1:0]          sample_enable;
    logic                           div_start;
    logic [ACC_W-1:0]               div_dividend;
    logic [ACC_W-1:0]               div_divisor;
    logic                           div_done;
    logic [SAMPLE_W-1:0]            div_quotient;
    logic [SAMPLE_W-1:0]            final_sample;
    logic                           final_valid;
    logic                           busy;
    logic                           overrun;
    logic [CNT_W-1:0]               voice_count;

    mix_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .sample_now    (sample_now),
        .samples       (samples),
        .sample_enable (sample_enable),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_done      (div_done),
        .div_quotient  (div_quotient),
        .final_sample  (final_sample),
        .final_valid   (final_valid),
        .busy          (busy),
        .overrun       (overrun),
        .voice_count   (voice_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string                          name;
        logic [NUM_VOICES-1:0]          en;
        logic [NUM_VOICES*SAMPLE_W-1:0] smp;
        int                             exp_sum;
        int                             exp_cnt;
        int                             exp_final;
    } vec_t;

    localparam int DIV_LAT = 5;
    localparam int N_VEC   = 5;

    vec_t vecs [N_VEC];
    vec_t v_scramble;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept edge ends cycle 0, then cycles are counted
    // from 1. Optionally pulses sample_now at cycle tick_at, and optionally
    // scrambles the live inputs right after the accept edge.
    task automatic run_tx(input vec_t v, input int tick_at, input bit scramble);
        int  cyc, starts, valids, start_cyc, valid_cyc, exp_valid;
        bit  use_div;
        use_div   = (v.exp_cnt != 0);
        exp_valid = use_div ? (13 + DIV_LAT + 1) : 13;
        cyc = 1; starts = 0; valids = 0; start_cyc = -1; valid_cyc = -1;
        samples       = v.smp;
        sample_enable = v.en;
        sample_now    = 1'b1;
        step();
        sample_now = 1'b0;
        if (scramble) begin
            samples       = '1;
            sample_enable = '1;
        end
        check({v.name, " busy after accept"}, busy, 1);
        while (valids == 0 && cyc < 60) begin
            div_done   = 1'b0;
            sample_now = 1'b0;
            if (div_start) begin
                starts++;
                if (start_cyc < 0) begin
                    start_cyc = cyc;
                    check({v.name, " dividend at start"}, div_dividend, v.exp_sum);
                    check({v.name, " divisor at start"}, div_divisor, v.exp_cnt);
                end
            end
            if (start_cyc >= 0 && cyc == start_cyc + DIV_LAT) begin
                check({v.name, " dividend held"}, div_dividend, v.exp_sum);
                div_done     = 1'b1;
                div_quotient = (div_divisor != '0) ? SAMPLE_W'(div_dividend / div_divisor) : '0;
            end
            if (final_valid) begin
                valids++;
                valid_cyc = cyc;
                check({v.name, " final_sample"}, final_sample, v.exp_final);
                check({v.name, " voice_count"}, voice_count, v.exp_cnt);
            end
            if (cyc == tick_at) sample_now = 1'b1;
            if (valids == 0) begin
                step();
                cyc++;
            end
        end
        div_done   = 1'b0;
        sample_now = 1'b0;
        check({v.name, " final_valid cycle"}, valid_cyc, exp_valid);
        if (use_div) check({v.name, " div_start cycle"}, start_cyc, 13);
        step();
        check({v.name, " idle after output"}, busy, 0);
        for (int k = 0; k < 4; k++) begin
            if (div_start)   starts++;
            if (final_valid) valids++;
            step();
        end
        check({v.name, " div_start pulses"}, starts, use_div ? 1 : 0);
        check({v.name, " final_valid pulses"}, valids, 1);
        check({v.name, " final_sample held"}, final_sample, v.exp_final);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " final_sample"}, final_sample, 0);
        check({tag, " final_valid"}, final_valid, 0);
        check({tag, " div_start"}, div_start, 0);
        check({tag, " div_dividend"}, div_dividend, 0);
        check({tag, " div_divisor"}, div_divisor, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " overrun"}, overrun, 0);
        check({tag, " voice_count"}, voice_count, 0);
    endtask

    initial begin
        // Vector table; disabled voices carry junk to prove they are masked.
        vecs[0].name = "voice3";  vecs[0].en = 12'h008; vecs[0].smp = {NUM_VOICES{8'h77}};
        vecs[0].smp[3*SAMPLE_W +: SAMPLE_W] = 8'd200;
        vecs[0].exp_sum = 200;  vecs[0].exp_cnt = 1;  vecs[0].exp_final = 200;

        vecs[1].name = "all255";  vecs[1].en = 12'hFFF; vecs[1].smp = {NUM_VOICES{8'hFF}};
        vecs[1].exp_sum = 3060; vecs[1].exp_cnt = 12; vecs[1].exp_final = 255;

        vecs[2].name = "none";    vecs[2].en = 12'h000; vecs[2].smp = {NUM_VOICES{8'h77}};
        vecs[2].exp_sum = 0;    vecs[2].exp_cnt = 0;  vecs[2].exp_final = 0;

        vecs[3].name = "v012";    vecs[3].en = 12'h007; vecs[3].smp = {NUM_VOICES{8'h77}};
        vecs[3].smp[0*SAMPLE_W +: SAMPLE_W] = 8'd10;
        vecs[3].smp[1*SAMPLE_W +: SAMPLE_W] = 8'd20;
        vecs[3].smp[2*SAMPLE_W +: SAMPLE_W] = 8'd30;
        vecs[3].exp_sum = 60;   vecs[3].exp_cnt = 3;  vecs[3].exp_final = 20;

        vecs[4].name = "v5_11";   vecs[4].en = 12'h820; vecs[4].smp = {NUM_VOICES{8'h33}};
        vecs[4].smp[5*SAMPLE_W +: SAMPLE_W]  = 8'd100;
        vecs[4].smp[11*SAMPLE_W +: SAMPLE_W] = 8'd51;
        vecs[4].exp_sum = 151;  vecs[4].exp_cnt = 2;  vecs[4].exp_final = 75;

        v_scramble.name = "scramble"; v_scramble.en = 12'h001; v_scramble.smp = {NUM_VOICES{8'h77}};
        v_scramble.smp[0 +: SAMPLE_W] = 8'd10;
        v_scramble.exp_sum = 10; v_scramble.exp_cnt = 1; v_scramble.exp_final = 10;

        reset = 1'b0; sample_now = 1'b0; samples = '0; sample_enable = '0;
        div_done = 1'b0; div_quotient = '0;
        step();
        step();
        check_reset_outputs("reset");
        reset = 1'b1;
        step();

        for (int i = 0; i < N_VEC; i++) begin
            run_tx(vecs[i], 0, 1'b0);
            check({vecs[i].name, " no overrun"}, overrun, 0);
        end

        // Tick during DIV_WAIT is dropped and flagged; flag survives the next transaction.
        run_tx(vecs[0], 15, 1'b0);
        check("overrun set", overrun, 1);
        run_tx(vecs[3], 0, 1'b0);
        check("overrun sticky", overrun, 1);

        // Live inputs changed after accept must not affect the result.
        run_tx(v_scramble, 0, 1'b1);

        // Reset mid-SCAN abandons the transaction and clears everything.
        samples = vecs[1].smp; sample_enable = vecs[1].en; sample_now = 1'b1;
        step();
        sample_now = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check("mid-scan busy before reset", busy, 1);
        reset = 1'b0;
        #1;
        check_reset_outputs("mid-scan reset");
        step();
        reset = 1'b1;
        // A late divider completion in IDLE is ignored.
        div_done = 1'b1; div_quotient = 8'd99;
        step();
        div_done = 1'b0;
        check("late done valid", final_valid, 0);
        check("late done busy", busy, 0);
        check("late done sample", final_sample, 0);
        step();
        check("late done valid later", final_valid, 0);

        run_tx(vecs[0], 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mix_sequencer.md
Name: mix_sequencer

Overview:
Per-sample controller for the voice mix/normalise/PWM path. On each sample-rate tick it snapshots the 12 waveshaper samples and the key enables, then serially accumulates the enabled voices over NUM_VOICES cycles. It drives the shared sequential divider through a start/done handshake and hands the normalised 8-bit result to the PWM stage with a one-cycle valid strobe. It replaces the combinational mixer and the ad-hoc OR-of-done start to the divider.

Parameters:
NUM_VOICES, 12, number of voices scanned per tick
SAMPLE_W, 8, width of each voice sample and of the final sample
ACC_W, 12, accumulator/dividend width; must hold NUM_VOICES*(2^SAMPLE_W-1) (3060 < 4096)
CNT_W, 4, width of the enabled-voice count

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
sample_now  in  1  one-cycle sample-rate tick
samples  in  NUM_VOICES*SAMPLE_W  voice samples; voice i occupies bits [i*SAMPLE_W +: SAMPLE_W]
sample_enable  in  NUM_VOICES  per-voice key enables
div_start  out  1  one-cycle start pulse to the divider
div_dividend  out  ACC_W  accumulated sum, held stable from div_start until div_done
div_divisor  out  ACC_W  zero-extended enabled count, held stable with div_dividend
div_done  in  1  divider completion pulse
div_quotient  in  SAMPLE_W  divider quotient, valid when div_done=1
final_sample  out  SAMPLE_W  registered normalised sample to the PWM stage
final_valid  out  1  one-cycle strobe; drives PWM start
busy  out  1  high in every state except IDLE
overrun  out  1  sticky flag: tick arrived while not IDLE
voice_count  out  CNT_W  enabled count of the last completed scan

Behaviour:
- Reset (async, reset=0): state IDLE; final_sample=0, final_valid=0, div_start=0, div_dividend=0, div_divisor=0, busy=0, overrun=0, voice_count=0; snapshot registers, accumulator, count and index cleared. Reset mid-transaction abandons it; late div_done after reset is ignored in IDLE.
- States: IDLE, SCAN, DIV_REQ, DIV_WAIT, OUTPUT.
- IDLE: on an edge with sample_now=1, capture samples and sample_enable into snapshot registers; acc=0, cnt=0, idx=0; go to SCAN. Input changes after capture have no effect on the transaction.
- SCAN: each cycle, if snap_en[idx] then acc+=snap_sample[idx], cnt+=1; idx+=1. This lasts exactly NUM_VOICES cycles. After idx=NUM_VOICES-1, go to DIV_REQ if the final cnt>0, else go to OUTPUT with final_sample<=0 (no divide by zero; divider untouched). voice_count<=final cnt.
- DIV_REQ: div_start=1 for exactly this one cycle; div_dividend=acc, div_divisor={0,cnt} registered at SCAN exit and held until the next transaction. Go to DIV_WAIT.
- DIV_WAIT: wait indefinitely for div_done. On div_done=1: final_sample<=div_quotient; go to OUTPUT. div_done seen in any other state is ignored.
- OUTPUT: final_valid=1 for this one cycle; go to IDLE. final_sample holds its value until the next OUTPUT.
- Latency: for an accept edge at cycle 0, SCAN occupies cycles 1..12. Zero voices: final_valid in cycle 13. Otherwise div_start in cycle 13, and final_valid one cycle after the div_done cycle.
- Overrun: sample_now=1 in any non-IDLE state (including OUTPUT) sets overrun=1 and drops the tick. overrun is cleared only by reset.
- Arithmetic: unsigned. No accumulator overflow is possible with the default parameters; an elaboration-time assertion checks the ACC_W rule.

Decomposition:
- Shared package synth_pkg: NUM_VOICES, SAMPLE_W, ACC_W, CNT_W constants, and enum seq_state_t {IDLE, SCAN, DIV_REQ, DIV_WAIT, OUTPUT}.
- No sub-module is required. The snapshot plus serial accumulate stays inline; the divider remains the existing external instance.

Test Plan:
- Reset, then hold reset low mid-SCAN: all outputs 0, state IDLE. After release, a sample_now starts a clean transaction.
- Only voice 3 enabled, sample 200; divider model answers 5 cycles after start: div_start exactly one pulse in cycle 13 with dividend=200, divisor=1. final_sample=200, final_valid single pulse, voice_count=1.
- All 12 enabled, every sample 255: dividend=3060, divisor=12; model returns 255, so final_sample=255 and voice_count=12.
- No voices enabled: no div_start ever; final_sample=0, final_valid in cycle 13, voice_count=0.
- sample_now pulsed during DIV_WAIT: overrun=1 and stays 1; exactly one div_start and one final_valid for the original tick.
- Enables/samples changed to all-ones during SCAN after accept (voice 0=10 only): result still dividend=10, divisor=1, final_sample=10.
